bounce_engine: RTL and testbench

BOUNCE_ENGINE -- requirements
Module: bounce_engine

---
 rtl/bounce_engine_if.sv | 27 ++
 rtl/bounce_engine.sv | 165 ++++++++++++++++
 tb/tb_bounce_engine.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bounce_engine_if.sv
// Frame/pixel bus between the video timing logic and the bounce engine.
interface bounce_engine_if #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
);
    logic                             frame_tick;
    logic                             pause;
    logic                             visible;
    logic [$clog2(SCREEN_WIDTH)-1:0]  position_x;
    logic [$clog2(SCREEN_HEIGHT)-1:0] position_y;
    logic [3:0]                       r;
    logic [3:0]                       g;
    logic [3:0]                       b;
    logic                             busy;
    logic                             overrun;
    logic [15:0]                      bounce_count;

    modport master (
        output frame_tick, pause, visible, position_x, position_y,
        input  r, g, b, busy, overrun, bounce_count
    );

    modport slave (
        input  frame_tick, pause, visible, position_x, position_y,
        output r, g, b, busy, overrun, bounce_count
    );
endinterface

// File: rtl/bounce_engine.sv
// Bouncing-box renderer: boxes move once per frame (one box per clock) and
// the pixel path paints the lowest-index box covering the current pixel.
module bounce_engine #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int NUM_BOXES     = 2,
    parameter int BOX_WIDTH     = 100,
    parameter int BOX_HEIGHT    = 100,
    parameter int VEL_W         = 4
) (
    input logic             clk,
    input logic             rst_n,
    bounce_engine_if.slave  bus
);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam int IW = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
    localparam logic signed [XW+1:0] LX = (XW+2)'(SCREEN_WIDTH - BOX_WIDTH);
    localparam logic signed [YW+1:0] LY = (YW+2)'(SCREEN_HEIGHT - BOX_HEIGHT);
    localparam logic [IW-1:0] LAST = IW'(NUM_BOXES - 1);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                   state, state_next;
    logic [IW-1:0]            index, index_next;

    logic [XW:0]              box_x     [NUM_BOXES];
    logic [YW:0]              box_y     [NUM_BOXES];
    logic signed [VEL_W-1:0]  box_xv    [NUM_BOXES];
    logic signed [VEL_W-1:0]  box_yv    [NUM_BOXES];
    logic [2:0]               box_color [NUM_BOXES];

    logic signed [XW+1:0]     tx;
    logic signed [YW+1:0]     ty;
    logic [XW:0]              new_x;
    logic [YW:0]              new_y;
    logic                     hit_x, hit_y;
    logic [2:0]               new_color;

    logic [NUM_BOXES-1:0]     in_box;
    logic                     pix_hit;
    logic [2:0]               pix_color;

    assign bus.busy = (state == UPDATE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        case (state)
            IDLE: begin
                if (bus.frame_tick && !bus.pause) begin
                    state_next = UPDATE;
                    index_next = '0;
                end
            end
            UPDATE: begin
                if (index == LAST) begin
                    state_next = IDLE;
                    index_next = '0;
                end else begin
                    index_next = index + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    // Trajectory is evaluated signed so a leftward/upward overshoot is seen as negative.
    always_comb begin
        tx = $signed({1'b0, box_x[index]}) + (XW+2)'(box_xv[index]);
        ty = $signed({1'b0, box_y[index]}) + (YW+2)'(box_yv[index]);

        if (tx < 0)       new_x = '0;
        else if (tx > LX) new_x = LX[XW:0];
        else              new_x = tx[XW:0];

        if (ty < 0)       new_y = '0;
        else if (ty > LY) new_y = LY[YW:0];
        else              new_y = ty[YW:0];

        hit_x = (tx < 0) || (tx >= LX);
        hit_y = (ty < 0) || (ty >= LY);
        new_color = (box_color[index] == 3'd7) ? 3'd1 : box_color[index] + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                box_x[i]     <= (XW+1)'(50 + 100 * i);
                box_y[i]     <= (YW+1)'(50 + 50 * i);
                box_xv[i]    <= VEL_W'(2);
                box_yv[i]    <= VEL_W'(1 + i);
                box_color[i] <= 3'(7 - i);
            end
        end else if (state == UPDATE) begin
            box_x[index] <= new_x;
            box_y[index] <= new_y;
            box_xv[index] <= hit_x ? -box_xv[index] : box_xv[index];
            box_yv[index] <= hit_y ? -box_yv[index] : box_yv[index];
            if (hit_x || hit_y) box_color[index] <= new_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overrun      <= 1'b0;
            bus.bounce_count <= '0;
        end else begin
            if (state == UPDATE && bus.frame_tick && !bus.pause) bus.overrun <= 1'b1;
            if (state == UPDATE && (hit_x || hit_y) && bus.bounce_count != 16'hFFFF)
                bus.bounce_count <= bus.bounce_count + 16'd1;
        end
    end

    // Scan from the top index down so the lowest-index covering box wins.
    always_comb begin
        pix_hit   = 1'b0;
        pix_color = 3'd0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            in_box[i] = ({2'b0, bus.position_x} >= {1'b0, box_x[i]}) &&
                        ({2'b0, bus.position_x} <  ({1'b0, box_x[i]} + (XW+2)'(BOX_WIDTH))) &&
                        ({2'b0, bus.position_y} >= {1'b0, box_y[i]}) &&
                        ({2'b0, bus.position_y} <  ({1'b0, box_y[i]} + (YW+2)'(BOX_HEIGHT)));
        end
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (in_box[i]) begin
                pix_hit   = 1'b1;
                pix_color = box_color[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.r <= 4'h0;
            bus.g <= 4'h0;
            bus.b <= 4'h0;
        end else if (!bus.visible) begin
            bus.r <= 4'h0;
            bus.g <= 4'h0;
            bus.b <= 4'h0;
        end else if (pix_hit) begin
            bus.r <= {4{pix_color[2]}};
            bus.g <= {4{pix_color[1]}};
            bus.b <= {4{pix_color[0]}};
        end else begin
            bus.r <= 4'b0001;
            bus.g <= 4'b0001;
            bus.b <= 4'b0001;
        end
    end
endmodule

// File: tb/tb_bounce_engine.sv
// Directed bench for bounce_engine: pixel vector table plus hand-traced
// multi-frame sequences on a default instance and a small single-box instance.
module tb_bounce_engine;
    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc;

    always #5 clk = ~clk;

    bounce_engine_if #(.SCREEN_WIDTH(640), .SCREEN_HEIGHT(480)) bus ();
    bounce_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Small screen: LX = 59, LY = 55, so the single box reaches a corner after five frames.
    bounce_engine_if #(.SCREEN_WIDTH(160), .SCREEN_HEIGHT(120)) small_bus ();
    bounce_engine #(
        .SCREEN_WIDTH(160), .SCREEN_HEIGHT(120), .NUM_BOXES(1),
        .BOX_WIDTH(101), .BOX_HEIGHT(65)
    ) small_dut (.clk(clk), .rst_n(rst_n), .bus(small_bus));

    typedef struct {
        logic       vis;
        int         px;
        int         py;
        logic [3:0] er;
        logic [3:0] eg;
        logic [3:0] eb;
    } pix_vec_t;

    pix_vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic vis, input int px, input int py);
        bus.visible    = vis;
        bus.position_x = 10'(px);
        bus.position_y = 9'(py);
    endtask

    task automatic send_tick(output int cycles);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 16) begin
            cycles++;
            step();
        end
    endtask

    task automatic send_small_tick(output int cycles);
        small_bus.frame_tick = 1'b1;
        step();
        small_bus.frame_tick = 1'b0;
        cycles = 0;
        while (small_bus.busy && cycles < 16) begin
            cycles++;
            step();
        end
    endtask

    task automatic check_boxes(input string tag, input int x0, input int y0, input int x1, input int y1);
        check_output({tag, " box0 x"}, 32'(dut.box_x[0]), x0);
        check_output({tag, " box0 y"}, 32'(dut.box_y[0]), y0);
        check_output({tag, " box1 x"}, 32'(dut.box_x[1]), x1);
        check_output({tag, " box1 y"}, 32'(dut.box_y[1]), y1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1,  60,  60, 4'hF, 4'hF, 4'hF};
        vecs[1]  = '{1'b1,  10,  10, 4'h1, 4'h1, 4'h1};
        vecs[2]  = '{1'b1, 160, 110, 4'hF, 4'hF, 4'h0};
        vecs[3]  = '{1'b1, 149, 149, 4'hF, 4'hF, 4'hF};
        vecs[4]  = '{1'b1, 150, 149, 4'hF, 4'hF, 4'h0};
        vecs[5]  = '{1'b1,  49,  60, 4'h1, 4'h1, 4'h1};
        vecs[6]  = '{1'b0,  60,  60, 4'h0, 4'h0, 4'h0};
        vecs[7]  = '{1'b1, 249, 199, 4'hF, 4'hF, 4'h0};
        vecs[8]  = '{1'b1, 250, 199, 4'h1, 4'h1, 4'h1};
        vecs[9]  = '{1'b1, 150, 200, 4'h1, 4'h1, 4'h1};
        vecs[10] = '{1'b1,  50,  50, 4'hF, 4'hF, 4'hF};

        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.pause = 1'b0;
        apply_stimulus(1'b1, 60, 60);
        small_bus.frame_tick = 1'b0;
        small_bus.pause = 1'b0;
        small_bus.visible = 1'b0;
        small_bus.position_x = '0;
        small_bus.position_y = '0;
        step();
        step();

        check_output("reset busy", 32'(bus.busy), 0);
        check_output("reset overrun", 32'(bus.overrun), 0);
        check_output("reset bounce_count", 32'(bus.bounce_count), 0);
        check_output("reset r", 32'(bus.r), 0);
        check_output("reset g", 32'(bus.g), 0);
        check_output("reset b", 32'(bus.b), 0);
        check_boxes("reset", 50, 50, 150, 100);
        check_output("reset box1 color", 32'(dut.box_color[1]), 6);
        check_output("reset box1 yv", 32'(dut.box_yv[1]), 2);

        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].vis, vecs[i].px, vecs[i].py);
            step();
            check_output($sformatf("pixel vec%0d r", i), 32'(bus.r), 32'(vecs[i].er));
            check_output($sformatf("pixel vec%0d g", i), 32'(bus.g), 32'(vecs[i].eg));
            check_output($sformatf("pixel vec%0d b", i), 32'(bus.b), 32'(vecs[i].eb));
        end

        send_tick(cyc);
        check_output("first tick busy cycles", cyc, 2);
        check_boxes("first tick", 52, 51, 152, 102);
        check_output("first tick bounce_count", 32'(bus.bounce_count), 0);
        check_output("first tick overrun", 32'(bus.overrun), 0);

        // Second tick held into the busy cycle must flag overrun without a second update.
        bus.frame_tick = 1'b1;
        step();
        step();
        bus.frame_tick = 1'b0;
        cyc = 1;
        while (bus.busy && cyc < 16) begin
            cyc++;
            step();
        end
        check_output("overrun busy cycles", cyc, 2);
        check_output("overrun flag", 32'(bus.overrun), 1);
        check_boxes("overrun frame", 54, 52, 154, 104);

        bus.pause = 1'b1;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        check_output("paused busy", 32'(bus.busy), 0);
        step();
        step();
        bus.pause = 1'b0;
        check_boxes("paused", 54, 52, 154, 104);
        check_output("paused overrun kept", 32'(bus.overrun), 1);

        apply_stimulus(1'b1, 60, 60);
        step();
        check_output("pre-abort r", 32'(bus.r), 32'hF);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        step();
        check_output("mid update box0 moved", 32'(dut.box_x[0]), 56);
        rst_n = 1'b0;
        #1;
        check_output("abort busy", 32'(bus.busy), 0);
        check_output("abort overrun", 32'(bus.overrun), 0);
        check_output("abort r", 32'(bus.r), 0);
        check_boxes("abort", 50, 50, 150, 100);
        step();
        rst_n = 1'b1;
        step();
        send_tick(cyc);
        check_output("post-abort busy cycles", cyc, 2);
        check_boxes("post-abort", 52, 51, 152, 102);

        // Frames 2..244: box1 bounces off the bottom at 140 and the right at 195.
        for (int n = 2; n <= 244; n++) send_tick(cyc);
        check_boxes("frame 244", 538, 294, 442, 172);
        check_output("frame 244 bounce_count", 32'(bus.bounce_count), 2);
        check_output("frame 244 box0 color", 32'(dut.box_color[0]), 7);
        check_output("frame 244 box1 color", 32'(dut.box_color[1]), 1);
        send_tick(cyc);
        check_boxes("frame 245", 540, 295, 440, 170);
        check_output("right hit box0 xv", 32'(dut.box_xv[0]), -2);
        check_output("right hit box0 color", 32'(dut.box_color[0]), 1);
        check_output("right hit bounce_count", 32'(bus.bounce_count), 3);
        check_output("long run overrun", 32'(bus.overrun), 0);
        apply_stimulus(1'b1, 600, 300);
        step();
        check_output("color1 pixel r", 32'(bus.r), 0);
        check_output("color1 pixel g", 32'(bus.g), 0);
        check_output("color1 pixel b", 32'(bus.b), 32'hF);

        for (int n = 1; n <= 4; n++) send_small_tick(cyc);
        check_output("small busy cycles", cyc, 1);
        check_output("small frame4 x", 32'(small_dut.box_x[0]), 58);
        check_output("small frame4 y", 32'(small_dut.box_y[0]), 54);
        check_output("small frame4 count", 32'(small_bus.bounce_count), 0);
        send_small_tick(cyc);
        check_output("corner x", 32'(small_dut.box_x[0]), 59);
        check_output("corner y", 32'(small_dut.box_y[0]), 55);
        check_output("corner xv", 32'(small_dut.box_xv[0]), -2);
        check_output("corner yv", 32'(small_dut.box_yv[0]), -1);
        check_output("corner color", 32'(small_dut.box_color[0]), 1);
        check_output("corner count", 32'(small_bus.bounce_count), 1);
        for (int n = 6; n <= 35; n++) send_small_tick(cyc);
        check_output("left clamp x", 32'(small_dut.box_x[0]), 0);
        check_output("left clamp y", 32'(small_dut.box_y[0]), 25);
        check_output("left clamp xv", 32'(small_dut.box_xv[0]), 2);
        check_output("left clamp color", 32'(small_dut.box_color[0]), 2);
        check_output("left clamp count", 32'(small_bus.bounce_count), 2);

        small_bus.frame_tick = 1'b1;
        step();
        step();
        small_bus.frame_tick = 1'b0;
        check_output("last-cycle tick overrun", 32'(small_bus.overrun), 1);
        check_output("last-cycle tick busy", 32'(small_bus.busy), 0);
        check_output("last-cycle tick x", 32'(small_dut.box_x[0]), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
